// File: rtl/mux_arb_n.sv
// mux_arb_n: registered NUM_IN-to-1 multiplexer with valid/ready handshakes.
//
// The block picks one candidate channel every cycle. In fixed mode the
// candidate is the channel given by sel. In round-robin mode it is the first
// valid channel found by searching from a rotating pointer. The winning beat
// is captured in a single output register. That register is allowed to load
// whenever it is empty or is draining in the same cycle.
//
// Optional feature: define MUX_ARB_LOCK_EN to add the in_last port and packet
// locking in round-robin mode. While a packet is in flight, arbitration stays
// on the channel that started it until that channel sends a beat with
// in_last set.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous, active-high; clears all state
//   in_data    NUM_IN*WIDTH flattened channel data, channel k at [k*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, at most one bit set
//   in_last    (MUX_ARB_LOCK_EN only) per-channel end-of-packet marker
//   mode       0 = fixed select, 1 = round-robin
//   sel        channel index used in fixed mode (values >= NUM_IN select nothing)
//   out_data   registered selected data
//   out_valid  out_data holds a beat
//   out_ready  consumer accepts the beat
//   out_src    channel index that produced out_data
module mux_arb_n #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
`ifdef MUX_ARB_LOCK_EN
  input  logic [NUM_IN-1:0]       in_last,
`endif
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_src
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] out_src_q, out_src_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
`ifdef MUX_ARB_LOCK_EN
  logic             lock_q, lock_d;
  logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
  logic             lock_hit;
  logic             cand_last;
`endif

  logic             load_en;
  logic             fix_hit;
  logic             rr_hit;
  logic [SEL_W-1:0] rr_idx;
  logic             cand_hit;
  logic [SEL_W-1:0] cand_sel;
  logic [WIDTH-1:0] cand_data;
  logic             xfer;
  logic [SEL_W-1:0] ptr_next;

  always_comb begin
    load_en = !out_valid_q || out_ready;

    // Fixed select: an out-of-range sel matches no channel, so nothing is offered.
    fix_hit = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (SEL_W'(k) == sel) fix_hit = in_valid[k];
    end

    // Round-robin search: offset i from ptr, first valid channel wins.
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      for (int k = 0; k < NUM_IN; k++) begin
        if (!rr_hit && in_valid[k] && (((int'(ptr_q) + i) % NUM_IN) == k)) begin
          rr_hit = 1'b1;
          rr_idx = SEL_W'(k);
        end
      end
    end

`ifdef MUX_ARB_LOCK_EN
    lock_hit = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (SEL_W'(k) == lock_ch_q) lock_hit = in_valid[k];
    end
`endif

    if (!mode) begin
      cand_sel = sel;
      cand_hit = fix_hit;
`ifdef MUX_ARB_LOCK_EN
    end else if (lock_q) begin
      cand_sel = lock_ch_q;
      cand_hit = lock_hit;
`endif
    end else begin
      cand_sel = rr_idx;
      cand_hit = rr_hit;
    end

    xfer = load_en && cand_hit;

    cand_data = '0;
`ifdef MUX_ARB_LOCK_EN
    cand_last = 1'b0;
`endif
    for (int k = 0; k < NUM_IN; k++) begin
      in_ready[k] = xfer && !reset && (SEL_W'(k) == cand_sel);
      if (SEL_W'(k) == cand_sel) begin
        cand_data = in_data[k*WIDTH +: WIDTH];
`ifdef MUX_ARB_LOCK_EN
        cand_last = in_last[k];
`endif
      end
    end

    ptr_next = (cand_sel == SEL_W'(NUM_IN - 1)) ? '0 : cand_sel + SEL_W'(1);

    out_valid_d = load_en ? xfer : out_valid_q;
    out_data_d  = xfer ? cand_data : out_data_q;
    out_src_d   = xfer ? cand_sel : out_src_q;
    ptr_d       = ptr_q;
`ifdef MUX_ARB_LOCK_EN
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
    if (!mode) begin
      lock_d = 1'b0;
    end else if (xfer) begin
      // A non-last beat pins arbitration to this channel; the last beat releases it.
      if (cand_last) begin
        lock_d = 1'b0;
        ptr_d  = ptr_next;
      end else begin
        lock_d    = 1'b1;
        lock_ch_d = cand_sel;
      end
    end
`else
    if (mode && xfer) ptr_d = ptr_next;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= '0;
      ptr_q       <= '0;
`ifdef MUX_ARB_LOCK_EN
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
`endif
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
`ifdef MUX_ARB_LOCK_EN
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// tb_mux_arb_n: self-checking bench for mux_arb_n (NUM_IN=4, SEL_W=3 so that
// out-of-range select values can be driven). Directed scenarios use fixed
// expected values; the random scenario uses a behavioural reference model.
module tb_mux_arb_n;
  localparam int WIDTH  = 32;
  localparam int NUM_IN = 4;
  localparam int SEL_W  = 3;

  logic                    clk;
  logic                    reset;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [NUM_IN-1:0]       in_last;
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [SEL_W-1:0]        out_src;

  int n_tests;
  int n_fail;

  // Reference model state
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic [SEL_W-1:0] m_src;
  int               m_ptr;
  logic             m_lock;
  int               m_lock_ch;
  // Model next-state and expected ready
  logic [NUM_IN-1:0] exp_ready;
  logic             n_valid;
  logic [WIDTH-1:0] n_data;
  logic [SEL_W-1:0] n_src;
  int               n_ptr;
  logic             n_lock;
  int               n_lock_ch;

  mux_arb_n #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
`ifdef MUX_ARB_LOCK_EN
    .in_last(in_last),
`endif
    .mode(mode),
    .sel(sel),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_src(out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_ch(input int k, input logic [WIDTH-1:0] v);
    in_data[k*WIDTH +: WIDTH] = v;
  endtask

  function automatic logic [WIDTH-1:0] get_ch(input int k);
    return in_data[k*WIDTH +: WIDTH];
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_src = '0; m_ptr = 0; m_lock = 1'b0; m_lock_ch = 0;
  endtask

  // Apply the arbitration rules to the current inputs and model state.
  task automatic model_eval();
    int  c;
    bit  hit;
    bit  load;
    bit  last;
    c = 0; hit = 0;
    if (mode == 1'b0) begin
      if (int'(sel) < NUM_IN && in_valid[sel]) begin hit = 1; c = int'(sel); end
    end else if (m_lock) begin
      c = m_lock_ch; hit = in_valid[c];
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        int k;
        k = (m_ptr + i) % NUM_IN;
        if (!hit && in_valid[k]) begin hit = 1; c = k; end
      end
    end
    load = !m_valid || out_ready;
    exp_ready = (load && hit) ? NUM_IN'(1 << c) : '0;
    n_valid = m_valid; n_data = m_data; n_src = m_src;
    n_ptr = m_ptr; n_lock = m_lock; n_lock_ch = m_lock_ch;
    if (load) n_valid = hit;
`ifdef MUX_ARB_LOCK_EN
    last = in_last[c];
`else
    last = 1'b1;
`endif
    if (load && hit) begin
      n_data = get_ch(c);
      n_src  = SEL_W'(c);
      if (mode) begin
        if (last) begin n_lock = 0; n_ptr = (c + 1) % NUM_IN; end
        else begin n_lock = 1; n_lock_ch = c; end
      end
    end
    if (!mode) n_lock = 0;
  endtask

  task automatic model_commit();
    m_valid = n_valid; m_data = n_data; m_src = n_src;
    m_ptr = n_ptr; m_lock = n_lock; m_lock_ch = n_lock_ch;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = '0; in_last = '1; out_ready = 1'b1; mode = 1'b0; sel = '0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = '1; mode = 1'b0; sel = '0; out_ready = 1'b1; in_last = '1;
    for (int k = 0; k < NUM_IN; k++) set_ch(k, 32'h5A5A0000 + k);
    @(posedge clk); #1;
    n_tests++;
    if ({out_valid, out_src, out_data} !== {1'b0, 3'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%0b src=%0d data=%h, want 0 0 0", out_valid, out_src, out_data);
    end
    n_tests++;
    if (in_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 0000", in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    in_valid = '0;
    model_reset();
  endtask

  task automatic test_fixed();
    do_reset();
    mode = 1'b0; sel = 3'd2; in_valid = 4'b0100; out_ready = 1'b1;
    set_ch(2, 32'hCAFE0002);
    #1;
    n_tests++;
    if (in_ready !== 4'b0100) begin
      n_fail++; $display("FAIL fixed_ready: got %b want 0100", in_ready);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({out_valid, out_src, out_data} !== {1'b1, 3'd2, 32'hCAFE0002}) begin
      n_fail++;
      $display("FAIL fixed_load: got valid=%0b src=%0d data=%h want 1 2 cafe0002", out_valid, out_src, out_data);
    end
    @(negedge clk);
    sel = 3'd1; in_valid = 4'b1000;
    #1;
    n_tests++;
    if (in_ready !== 4'b0000) begin
      n_fail++; $display("FAIL fixed_unselected_ready: got %b want 0000", in_ready);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({out_valid, out_data} !== {1'b0, 32'hCAFE0002}) begin
      n_fail++;
      $display("FAIL fixed_unselected_out: got valid=%0b data=%h want 0 cafe0002", out_valid, out_data);
    end
    @(negedge clk);
    sel = 3'd5; in_valid = 4'b1111;
    #1;
    n_tests++;
    if (in_ready !== 4'b0000) begin
      n_fail++; $display("FAIL fixed_sel_oob_ready: got %b want 0000", in_ready);
    end
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL fixed_sel_oob_out: got valid=%0b want 0", out_valid);
    end
    @(negedge clk);
    in_valid = '0;
  endtask

  task automatic test_round_robin();
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < NUM_IN; k++) set_ch(k, 32'hA0000000 + k);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if (in_ready !== 4'(1 << (i % 4))) begin
        n_fail++; $display("FAIL rr_ready_%0d: got %b want %b", i, in_ready, 4'(1 << (i % 4)));
      end
      @(posedge clk); #1;
      n_tests++;
      if ({out_valid, out_src, out_data} !== {1'b1, 3'(i % 4), 32'hA0000000 + 32'(i % 4)}) begin
        n_fail++;
        $display("FAIL rr_seq_%0d: got valid=%0b src=%0d data=%h want src %0d", i, out_valid, out_src, out_data, i % 4);
      end
      @(negedge clk);
    end
    in_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 1'b0; sel = 3'd0; in_valid = 4'b0001; out_ready = 1'b1;
    set_ch(0, 32'h11111111);
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 4'($urandom_range(15)) | 4'b0001;
      sel = 3'($urandom_range(3));
      for (int k = 0; k < NUM_IN; k++) set_ch(k, $urandom);
      #1;
      n_tests++;
      if (in_ready !== 4'b0000) begin
        n_fail++; $display("FAIL stall_ready_%0d: got %b want 0000", i, in_ready);
      end
      @(posedge clk); #1;
      n_tests++;
      if ({out_valid, out_src, out_data} !== {1'b1, 3'd0, 32'h11111111}) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: got valid=%0b src=%0d data=%h want 1 0 11111111", i, out_valid, out_src, out_data);
      end
      @(negedge clk);
    end
    out_ready = 1'b1; sel = 3'd1; in_valid = 4'b0010;
    set_ch(1, 32'h22222222);
    #1;
    n_tests++;
    if (in_ready !== 4'b0010) begin
      n_fail++; $display("FAIL drain_ready: got %b want 0010", in_ready);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({out_valid, out_src, out_data} !== {1'b1, 3'd1, 32'h22222222}) begin
      n_fail++;
      $display("FAIL drain_load: got valid=%0b src=%0d data=%h want 1 1 22222222", out_valid, out_src, out_data);
    end
    @(negedge clk);
    in_valid = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0100;
    set_ch(2, 32'hDEAD0002);
    @(posedge clk); @(negedge clk);
    // Beat from ch2 is held and ptr is 3; pulse reset between clock edges.
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({out_valid, out_src, out_data} !== {1'b0, 3'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%0b src=%0d data=%h want 0 0 0", out_valid, out_src, out_data);
    end
    n_tests++;
    if (in_ready !== 4'b0000) begin
      n_fail++; $display("FAIL async_reset_ready: got %b want 0000", in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    in_valid = 4'b1111;
    for (int k = 0; k < NUM_IN; k++) set_ch(k, 32'hB0000000 + k);
    @(posedge clk); #1;
    n_tests++;
    if ({out_valid, out_src} !== {1'b1, 3'd0}) begin
      n_fail++; $display("FAIL reset_ptr: got valid=%0b src=%0d want 1 0", out_valid, out_src);
    end
    @(negedge clk);
    in_valid = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0100;
    for (int k = 0; k < NUM_IN; k++) set_ch(k, 32'hC0000000 + k);
    @(posedge clk); @(negedge clk);
    in_valid = 4'b0001;
    #1;
    n_tests++;
    if (in_ready !== 4'b0001) begin
      n_fail++; $display("FAIL wrap_ready: got %b want 0001", in_ready);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({out_valid, out_src} !== {1'b1, 3'd0}) begin
      n_fail++; $display("FAIL wrap_src: got valid=%0b src=%0d want 1 0", out_valid, out_src);
    end
    @(negedge clk);
    in_valid = 4'b1111;
    @(posedge clk); #1;
    n_tests++;
    if ({out_valid, out_src} !== {1'b1, 3'd1}) begin
      n_fail++; $display("FAIL wrap_ptr: got valid=%0b src=%0d want 1 1", out_valid, out_src);
    end
    @(negedge clk);
    in_valid = '0;
  endtask

`ifdef MUX_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0110; in_last = 4'b1111;
    set_ch(1, 32'hD1D1D1D1); set_ch(2, 32'hD2D2D2D2);
    for (int i = 0; i < 4; i++) begin
      in_last[1] = (i == 2);
      @(posedge clk); #1;
      n_tests++;
      if (out_src !== ((i < 3) ? 3'd1 : 3'd2)) begin
        n_fail++; $display("FAIL lock_seq_%0d: got src=%0d want %0d", i, out_src, (i < 3) ? 1 : 2);
      end
      @(negedge clk);
    end
    in_valid = '0; in_last = '1;
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid  = 4'($urandom_range(15));
      mode      = ($urandom_range(3) != 0);
      sel       = 3'($urandom_range(7));
      out_ready = ($urandom_range(3) != 0);
      in_last   = 4'($urandom_range(15));
      for (int k = 0; k < NUM_IN; k++) set_ch(k, $urandom);
      #1;
      model_eval();
      n_tests++;
      if (in_ready !== exp_ready) begin
        n_fail++; $display("FAIL rand_ready_%0d: got %b want %b", i, in_ready, exp_ready);
      end
      @(posedge clk);
      model_commit();
      #1;
      n_tests++;
      if ({out_valid, out_src} !== {m_valid, m_src} || (m_valid && out_data !== m_data)) begin
        n_fail++;
        $display("FAIL rand_out_%0d: got valid=%0b src=%0d data=%h want %0b %0d %h",
                 i, out_valid, out_src, out_data, m_valid, m_src, m_data);
      end
      @(negedge clk);
    end
    in_valid = '0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    in_data = '0;
    model_reset();
    test_reset();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_async_reset();
    test_wrap();
`ifdef MUX_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
